// File: rtl/dlfloat16_div_round_out_if.sv
// Handshake bundle between the DLFloat16 divider, the rounding stage and the
// result consumer.
//   in_valid/in_ready/in_res/in_flags     : divider -> rounding stage
//   out_valid/out_ready/out_data/out_flags: rounding stage -> consumer
// master is the environment side (drives inputs, consumes outputs);
// slave is the rounding stage itself.
interface dlfloat16_div_round_out_if;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_res;
  logic [4:0]  in_flags;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [4:0]  out_flags;

  modport master (
    output in_valid, in_res, in_flags, out_ready,
    input  in_ready, out_valid, out_data, out_flags
  );

  modport slave (
    input  in_valid, in_res, in_flags, out_ready,
    output in_ready, out_valid, out_data, out_flags
  );
endinterface

// File: rtl/dlfloat16_div_round_out.sv
// Rounding/writeback stage behind the DLFloat16 divider.
// Stage 1 registers the divider's unrounded {s, exp[5:0], 1.mant[8:0], G, R, S}
// result after round-to-nearest-even, exponent fix-up and flag merge. Stage 2
// is a show-ahead FIFO of DEPTH entries feeding a valid/ready consumer.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   clr   : synchronous flush of stage 1 and the FIFO (beats push/pop)
//   bus   : slave side of dlfloat16_div_round_out_if (in_* from the divider,
//           out_* toward the consumer)
module dlfloat16_div_round_out #(
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  dlfloat16_div_round_out_if.slave    bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Round one divider result; returns {data[15:0], flags[4:0]}.
  // Flag order: {invalid, inexact, overflow, underflow, div_by_zero}.
  function automatic logic [20:0] round_rne(input logic [19:0] res,
                                            input logic [4:0]  flags);
    logic        sign_s;
    logic [5:0]  exp_s;
    logic [8:0]  mant_s;
    logic        g_s;
    logic        r_s;
    logic        st_s;
    logic        rnd_up_s;
    logic [9:0]  m9_s;
    logic [15:0] data_s;
    logic [4:0]  flags_s;
    sign_s   = res[19];
    exp_s    = res[18:13];
    mant_s   = res[11:3];
    g_s      = res[2];
    r_s      = res[1];
    st_s     = res[0];
    flags_s  = flags;
    rnd_up_s = g_s & (r_s | st_s | mant_s[0]);
    m9_s     = {1'b0, mant_s} + {9'h000, rnd_up_s};
    if (res[18:0] == 19'h00000) begin
      data_s = {sign_s, 15'h0000};
    end else if (exp_s == 6'h3F) begin
      // inf/NaN payload is carried through unrounded
      data_s = {sign_s, 6'h3F, mant_s};
    end else begin
      flags_s[3] = flags[3] | g_s | r_s | st_s;
      if (m9_s[9]) begin
        // mantissa overflowed into the hidden bit: renormalise
        if (exp_s == 6'h3E) begin
          // exp 63 would encode inf/NaN, so clamp to the largest finite value
          data_s     = {sign_s, 6'h3E, 9'h1FF};
          flags_s[2] = 1'b1;
        end else begin
          data_s = {sign_s, exp_s + 6'h01, 9'h000};
        end
      end else begin
        data_s = {sign_s, exp_s, m9_s[8:0]};
      end
    end
    return {data_s, flags_s};
  endfunction

  logic              s1_valid_r;
  logic [15:0]       s1_data_r;
  logic [4:0]        s1_flags_r;
  logic [15:0]       mem_data_r  [DEPTH];
  logic [4:0]        mem_flags_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;

  logic              transfer_s;
  logic              push_s;
  logic              pop_s;
  logic [CW:0]       occupancy_s;
  logic [20:0]       rounded_s;

  // Space is reserved for the entry already in stage 1, so stage 1 never stalls.
  assign occupancy_s   = {1'b0, count_r} + {{CW{1'b0}}, s1_valid_r};
  assign bus.in_ready  = (occupancy_s < (CW+1)'(DEPTH));
  assign transfer_s    = bus.in_valid & bus.in_ready;
  assign push_s        = s1_valid_r;
  assign pop_s         = bus.out_valid & bus.out_ready;
  assign rounded_s     = round_rne(bus.in_res, bus.in_flags);

  assign bus.out_valid = (count_r != {CW{1'b0}});
  assign bus.out_data  = mem_data_r[rd_ptr_r];
  assign bus.out_flags = mem_flags_r[rd_ptr_r];

  // Stage 1: capture the rounded result of each accepted input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= 16'h0000;
      s1_flags_r <= 5'h00;
    end else if (clr) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= transfer_s;
      if (transfer_s) begin
        s1_data_r  <= rounded_s[20:5];
        s1_flags_r <= rounded_s[4:0];
      end
    end
  end

  // Stage 2: show-ahead FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data_r[i]  <= 16'h0000;
        mem_flags_r[i] <= 5'h00;
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (clr) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        mem_data_r[wr_ptr_r]  <= s1_data_r;
        mem_flags_r[wr_ptr_r] <= s1_flags_r;
        wr_ptr_r              <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_dlfloat16_div_round_out.sv
// Self-checking bench for dlfloat16_div_round_out: directed steps plus a
// scoreboard of expected results produced by an independent rounding model.
module tb_dlfloat16_div_round_out;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;

  always #5 clk = ~clk;

  dlfloat16_div_round_out_if bus ();

  dlfloat16_div_round_out #(.DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [20:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference rounding done on integers: value of the dropped GRS bits vs half.
  function automatic logic [20:0] model(input logic [19:0] r, input logic [4:0] f);
    logic       s;
    int         e;
    int         m;
    int         grs;
    logic [4:0] fo;
    logic [5:0] e6;
    logic [8:0] m9;
    s   = r[19];
    e   = int'(r[18:13]);
    m   = int'(r[11:3]);
    grs = int'(r[2:0]);
    fo  = f;
    if (r[18:0] == 19'h00000) return {s, 15'h0000, f};
    if (e == 63) return {s, 6'h3F, r[11:3], f};
    if (grs != 0) fo[3] = 1'b1;
    if (grs > 4 || (grs == 4 && (m % 2) == 1)) m = m + 1;
    if (m == 512) begin
      m = 0;
      e = e + 1;
    end
    if (e == 63) begin
      fo[2] = 1'b1;
      return {s, 6'h3E, 9'h1FF, fo};
    end
    e6 = 6'(e);
    m9 = 9'(m);
    return {s, e6, m9, fo};
  endfunction

  // Scoreboard: record accepted inputs, compare the FIFO head whenever valid.
  always @(negedge clk) begin
    if (!rst_n || clr) begin
      sb_q.delete();
    end else begin
      if (bus.out_valid) begin
        if (sb_q.size() == 0) begin
          chk("spurious_out_valid", 32'(bus.out_valid), 32'h0);
        end else begin
          chk("out_data", 32'(bus.out_data), 32'(sb_q[0][20:5]));
          chk("out_flags", 32'(bus.out_flags), 32'(sb_q[0][4:0]));
          if (bus.out_ready) void'(sb_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) sb_q.push_back(model(bus.in_res, bus.in_flags));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [19:0] r, input logic [4:0] f);
    bus.in_valid = 1'b1;
    bus.in_res   = r;
    bus.in_flags = f;
    cyc();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb_q.size() != 0; i++) cyc();
    chk("drain_timeout", 32'(sb_q.size()), 32'h0);
  endtask

  initial begin
    int n;
    rst_n         = 1'b0;
    clr           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_res    = 20'h00000;
    bus.in_flags  = 5'h00;
    bus.out_ready = 1'b1;
    cyc();
    cyc();
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_data", 32'(bus.out_data), 32'h0);
    chk("rst_out_flags", 32'(bus.out_flags), 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    rst_n = 1'b1;
    cyc();

    // Tie-even, also probes the two-cycle latency
    send({1'b0, 6'd31, 1'b1, 9'h000, 3'b100}, 5'b00000);
    chk("latency_n", 32'(bus.out_valid), 32'h0);
    cyc();
    chk("latency_n1", 32'(bus.out_valid), 32'h1);
    chk("tie_even_data", 32'(bus.out_data), 32'h3E00);
    chk("tie_even_flags", 32'(bus.out_flags), 32'h08);
    drain();

    send({1'b0, 6'd31, 1'b1, 9'h001, 3'b100}, 5'b00000);
    send({1'b0, 6'd31, 1'b1, 9'h1FF, 3'b110}, 5'b00000);
    send({1'b0, 6'd62, 1'b1, 9'h1FF, 3'b100}, 5'b00000);
    send({1'b1, 6'h3F, 13'h0000}, 5'b00001);
    send({1'b1, 19'h00000}, 5'b10010);
    send({1'b0, 6'd5, 1'b1, 9'h0AA, 3'b011}, 5'b00000);
    send({1'b1, 6'd40, 1'b1, 9'h0AB, 3'b101}, 5'b00010);
    drain();
    // Spot check the table values explicitly as well
    send({1'b0, 6'd62, 1'b1, 9'h1FF, 3'b100}, 5'b00000);
    cyc();
    chk("overflow_data", 32'(bus.out_data), 32'h7DFF);
    chk("overflow_flags", 32'(bus.out_flags), 32'h0C);
    drain();
    send({1'b0, 6'd31, 1'b1, 9'h1FF, 3'b110}, 5'b00000);
    cyc();
    chk("carry_data", 32'(bus.out_data), 32'h4000);
    drain();

    // Backpressure: exactly DEPTH transfers while the consumer stalls
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      bus.in_res   = 20'($urandom);
      bus.in_flags = 5'($urandom_range(0, 31));
      @(negedge clk);
      if (bus.in_ready) n++;
      cyc();
    end
    bus.in_valid = 1'b0;
    chk("bp_transfers", 32'(n), 32'd4);
    cyc();
    chk("bp_in_ready_full", 32'(bus.in_ready), 32'h0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_drain_valid", 32'(bus.out_valid), 32'h1);
    end
    @(negedge clk);
    chk("bp_drain_empty", 32'(bus.out_valid), 32'h0);
    chk("bp_sb_empty", 32'(sb_q.size()), 32'h0);
    cyc();

    // clr mid-burst: the input offered during clr is dropped too
    bus.out_ready = 1'b0;
    send(20'h3E123, 5'h00);
    send(20'h21FFF, 5'h01);
    send(20'h40004, 5'h02);
    clr          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_res   = 20'h3E001;
    cyc();
    clr          = 1'b0;
    bus.in_valid = 1'b0;
    chk("clr_out_valid", 32'(bus.out_valid), 32'h0);
    chk("clr_in_ready", 32'(bus.in_ready), 32'h1);
    cyc();
    chk("clr_dropped", 32'(bus.out_valid), 32'h0);
    bus.out_ready = 1'b1;
    send({1'b0, 6'd10, 1'b1, 9'h155, 3'b111}, 5'b00000);
    drain();

    // Asynchronous reset in the middle of a burst
    bus.out_ready = 1'b0;
    send(20'h12345, 5'h04);
    send(20'h2ABCD, 5'h00);
    cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("arst_out_data", 32'(bus.out_data), 32'h0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'h1);
    cyc();
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    cyc();
    send({1'b1, 6'd1, 1'b1, 9'h0FF, 3'b100}, 5'b00000);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
